// File: rtl/gate_sweep_checker.sv
// Purpose: drives a 2-input gate through codes 00,10,11,01 and checks O against TRUTH.
// Latency: done pulses 4*(SETTLE_CYCLES+1)+1 cycles after the accepted start edge.
// Backpressure: none; start is accepted only in IDLE, otherwise ignored (no queueing).
module gate_sweep_checker #(
    parameter logic [3:0] TRUTH         = 4'b1001,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       drive_a,
    output logic       drive_b,
    input  logic       dut_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
);

    // The settle counter is 8 bits wide, so the window must fit in 1..255.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("gate_sweep_checker: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] step;
    logic [7:0] settle_cnt;

    // Gray-ordered vector table, value is {A,B}.
    function automatic logic [1:0] vec(input logic [1:0] s);
        case (s)
            2'd0:    vec = 2'b00;
            2'd1:    vec = 2'b10;
            2'd2:    vec = 2'b11;
            default: vec = 2'b01;
        endcase
    endfunction

    // Sweep sequencer: all outputs are registered and move only on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= 2'd0;
            settle_cnt <= 8'd0;
            drive_a    <= 1'b0;
            drive_b    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_mask   <= 4'b0000;
            err_count  <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        busy       <= 1'b1;
                        step       <= 2'd0;
                        settle_cnt <= 8'd0;
                        drive_a    <= 1'b0;
                        drive_b    <= 1'b0;
                        err_mask   <= 4'b0000;
                        err_count  <= 3'd0;
                        pass       <= 1'b0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // dut_o is taken straight from the gate; the settle window covers its delay.
                    if (dut_o != TRUTH[{drive_a, drive_b}]) begin
                        err_mask[{drive_a, drive_b}] <= 1'b1;
                        err_count                    <= err_count + 3'd1;
                    end
                    if (step != 2'd3) begin
                        step                 <= step + 2'd1;
                        {drive_a, drive_b}   <= vec(step + 2'd1);
                        settle_cnt           <= 8'd0;
                        state                <= SETTLE;
                    end else begin
                        // Last vector is released as soon as the sweep leaves SAMPLE.
                        state   <= DONE;
                        busy    <= 1'b0;
                        drive_a <= 1'b0;
                        drive_b <= 1'b0;
                    end
                end
                default: begin
                    // DONE: err_mask is final here, so pass can be resolved from it.
                    done  <= 1'b1;
                    pass  <= (err_mask == 4'b0000);
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (XNOR default, XOR table, AND with 1-cycle settle).
// Stimulus tasks push expected results; a per-instance monitor pops and compares on done.
// Gate behaviour behind each instance is selected at run time (xnor, tied 0, xor, and).
module tb_gate_sweep_checker;

    typedef struct {
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       pass;
        int         due;
    } exp_t;

    localparam logic [11:0] TRV = {4'b1000, 4'b0110, 4'b1001};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [3];
    logic       dut_o [3];
    logic       drv_a [3];
    logic       drv_b [3];
    logic       busy  [3];
    logic       done  [3];
    logic       pass  [3];
    logic [3:0] mask  [3];
    logic [2:0] ecnt  [3];
    int         gmode [3];
    int         dseen [3];
    int         dexp  [3];
    exp_t       sbq   [3][$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gate(input int m, input logic a, input logic b);
        case (m)
            0:       gate = ~(a ^ b);
            1:       gate = 1'b0;
            2:       gate = a ^ b;
            default: gate = a & b;
        endcase
    endfunction

    function automatic logic [1:0] vec(input int s);
        case (s)
            0:       vec = 2'b00;
            1:       vec = 2'b10;
            2:       vec = 2'b11;
            default: vec = 2'b01;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_u
        gate_sweep_checker #(
            .TRUTH        (TRV[g*4 +: 4]),
            .SETTLE_CYCLES((g == 2) ? 1 : 2)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[g]),
            .drive_a  (drv_a[g]),
            .drive_b  (drv_b[g]),
            .dut_o    (dut_o[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .pass     (pass[g]),
            .err_mask (mask[g]),
            .err_count(ecnt[g])
        );

        assign dut_o[g] = gate(gmode[g], drv_a[g], drv_b[g]);

        // Monitor: every done pulse must match the oldest outstanding expectation.
        always @(negedge clk) begin
            if (done[g]) begin
                exp_t e;
                dseen[g] = dseen[g] + 1;
                if (sbq[g].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done u%0d: done seen at cycle %0d, none expected", g, cyc);
                end else begin
                    e = sbq[g].pop_front();
                    chk($sformatf("u%0d done_cycle", g), cyc, e.due);
                    chk($sformatf("u%0d err_mask", g), int'(mask[g]), int'(e.mask));
                    chk($sformatf("u%0d err_count", g), int'(ecnt[g]), int'(e.cnt));
                    chk($sformatf("u%0d pass", g), int'(pass[g]), int'(e.pass));
                end
            end
        end
    end

    // One full sweep on instance idx; poke re-pulses start mid-sweep and across DONE.
    task automatic sweep(input int idx, input int mode, input logic [3:0] em,
                         input logic [2:0] ec, input logic ep, input bit poke);
        int   per;
        exp_t e;
        per = (idx == 2) ? 2 : 3;
        gmode[idx] = mode;
        @(negedge clk);
        start[idx] = 1'b1;
        e.mask = em;
        e.cnt  = ec;
        e.pass = ep;
        e.due  = cyc + 1 + 4 * per + 1;
        sbq[idx].push_back(e);
        dexp[idx]++;
        @(posedge clk);
        #1 start[idx] = 1'b0;
        for (int k = 0; k <= 4 * per + 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk($sformatf("u%0d start_clears_mask", idx), int'(mask[idx]), 0);
                chk($sformatf("u%0d start_clears_count", idx), int'(ecnt[idx]), 0);
                chk($sformatf("u%0d start_clears_pass", idx), int'(pass[idx]), 0);
            end
            chk($sformatf("u%0d drive k=%0d", idx, k), int'({drv_a[idx], drv_b[idx]}),
                (k < 4 * per) ? int'(vec(k / per)) : 0);
            chk($sformatf("u%0d busy k=%0d", idx, k), int'(busy[idx]), (k < 4 * per) ? 1 : 0);
            if (poke) start[idx] = (k == 6 || k == 11 || k == 12);
        end
        start[idx] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            gmode[i] = 0;
            dseen[i] = 0;
            dexp[i]  = 0;
        end
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst busy", int'(busy[0]), 0);
        chk("rst drive", int'({drv_a[0], drv_b[0]}), 0);
        chk("rst done", int'(done[0]), 0);
        chk("rst pass", int'(pass[0]), 0);
        chk("rst err_mask", int'(mask[0]), 0);
        chk("rst err_count", int'(ecnt[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct XNOR gate
        sweep(0, 0, 4'b0000, 3'd0, 1'b1, 1'b0);
        // Output tied low: codes 00 and 11 expect 1
        sweep(0, 1, 4'b1001, 3'd2, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("hold err_mask", int'(mask[0]), 4'b1001);
        chk("hold err_count", int'(ecnt[0]), 2);
        chk("hold pass", int'(pass[0]), 0);
        // XOR gate against XNOR table, then against XOR table
        sweep(0, 2, 4'b1111, 3'd4, 1'b0, 1'b0);
        sweep(1, 2, 4'b0000, 3'd0, 1'b1, 1'b0);
        // AND gate with single-cycle settle
        sweep(2, 3, 4'b0000, 3'd0, 1'b1, 1'b0);
        // start re-pulsed in step2 SETTLE and across the DONE cycle
        sweep(0, 0, 4'b0000, 3'd0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("no_restart busy", int'(busy[0]), 0);

        // Reset during step1 SAMPLE with a failing gate
        gmode[0] = 1;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst err_mask", int'(mask[0]), 4'b0001);
        chk("pre_rst drive", int'({drv_a[0], drv_b[0]}), 2'b10);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", int'(busy[0]), 0);
        chk("midrst drive", int'({drv_a[0], drv_b[0]}), 0);
        chk("midrst err_mask", int'(mask[0]), 0);
        chk("midrst err_count", int'(ecnt[0]), 0);
        chk("midrst pass", int'(pass[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        chk("midrst no_done", dseen[0], dexp[0]);
        chk("midrst idle", int'(busy[0]), 0);
        sweep(0, 0, 4'b0000, 3'd0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d pending", i), sbq[i].size(), 0);
            chk($sformatf("u%0d done_total", i), dseen[i], dexp[i]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
